// File: rtl/vedic_defs.sv
// vedic_defs: shared constants, state encoding and step schedule for the Vedic datapath.
package vedic_defs;
    localparam int OPW   = 8;
    localparam int NIBW  = 4;
    localparam int STEPS = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    function automatic logic [3:0] shift_of(input logic [1:0] s);
        return s == 2'd0 ? 4'd0 : s == 2'd3 ? 4'd8 : 4'd4;
    endfunction
endpackage

// File: rtl/vedic_mul8x8_seq_if.sv
// vedic_mul8x8_seq_if: start/done handshake and operand/product bus of the sequential multiplier.
interface vedic_mul8x8_seq_if;
    logic                          start;
    logic [vedic_defs::OPW-1:0]    a;
    logic [vedic_defs::OPW-1:0]    b;
    logic                          busy;
    logic                          done;
    logic [2*vedic_defs::OPW-1:0]  product;
    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/vedic4x4.sv
// vedic4x4: combinational 4x4 Vedic multiplier from four 2x2 cells and 4-bit ripple-carry adders.
module vedic4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    function automatic logic [3:0] m2(input logic [1:0] u, input logic [1:0] v);
        logic c;
        c = u[1] & v[0] & u[0] & v[1];
        return {u[1] & v[1] & c, (u[1] & v[1]) ^ c, (u[1] & v[0]) ^ (u[0] & v[1]), u[0] & v[0]};
    endfunction
    function automatic logic [4:0] rca4(input logic [3:0] u, input logic [3:0] v);
        logic [4:0] c;
        logic [3:0] s;
        c[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s[i]   = u[i] ^ v[i] ^ c[i];
            c[i+1] = (u[i] & v[i]) | (c[i] & (u[i] ^ v[i]));
        end
        return {c[4], s};
    endfunction
    logic [3:0] p0, p1, p2, p3;
    logic [4:0] s1, t;
    assign p0 = m2(x[1:0], y[1:0]);
    assign p1 = m2(x[3:2], y[1:0]);
    assign p2 = m2(x[1:0], y[3:2]);
    assign p3 = m2(x[3:2], y[3:2]);
    assign s1 = rca4(p1, p2);
    assign t  = rca4(s1[3:0], {2'b00, p0[3:2]});
    // cross terms sum to at most 21, so at most one of the two carries is set
    assign p = {4'(rca4(p3, {1'b0, s1[4] | t[4], t[3:2]})), t[1:0], p0[1:0]};
endmodule

// File: rtl/vedic_mul8x8_seq.sv
// vedic_mul8x8_seq: 8x8 unsigned multiplier reusing one 4x4 Vedic core over four
// nibble steps, summed by a 16-bit shift-and-add accumulator behind a start/done handshake.
module vedic_mul8x8_seq
    import vedic_defs::*;
(
    input logic               clk,
    input logic               rst_n,
    vedic_mul8x8_seq_if.slave bus
);
    localparam logic [1:0] LAST = 2'(STEPS - 1);
    state_t            state, state_n;
    logic [1:0]        step;
    logic [OPW-1:0]    ra, rb;
    logic [2*OPW-1:0]  acc, sum, product;
    logic              done;
    logic [NIBW-1:0]   na, nb;
    logic [2*NIBW-1:0] pp;
    // step bit 0 selects the high multiplicand nibble, bit 1 the high multiplier nibble
    assign na = step[0] ? ra[7:4] : ra[3:0];
    assign nb = step[1] ? rb[7:4] : rb[3:0];
    vedic4x4 core (.x(na), .y(nb), .p(pp));
    assign sum = acc + ({8'd0, pp} << shift_of(step));
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (bus.start ? CALC : IDLE) :
                  state == CALC ? (step == LAST ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ra      <= '0;
            rb      <= '0;
            acc     <= '0;
            step    <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= state == CALC && step == LAST;
            if (state == IDLE && bus.start) begin
                ra   <= bus.a;
                rb   <= bus.b;
                acc  <= '0;
                step <= '0;
            end
            if (state == CALC) begin
                acc  <= sum;
                step <= step + 2'd1;
                if (step == LAST) product <= sum;
            end
        end
    assign bus.busy    = state != IDLE;
    assign bus.done    = done;
    assign bus.product = product;
endmodule

// File: tb/tb_vedic_mul8x8_seq.sv
// tb_vedic_mul8x8_seq: directed and randomized checks of the sequential multiplier
// against plain a*b and an accept-every-6th-edge timing model.
module tb_vedic_mul8x8_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] prev_prod;
    int ndone, at, nbusy;
    int next_ok, got;
    logic [7:0] da, db;
    int q_edge[$];
    logic [15:0] q_prod[$];
    logic exp_done;

    vedic_mul8x8_seq_if bus ();
    vedic_mul8x8_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one operation; poke=1 drives a start attempt during CALC
    task automatic op(input logic [7:0] x, input logic [7:0] y, input string tag, input bit poke);
        logic [15:0] exp_p;
        exp_p = 16'(x) * 16'(y);
        bus.a = x; bus.b = y; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 8'($urandom);
        ndone = 0; at = 0; nbusy = bus.busy ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            if (poke && i == 1) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; end
            if (poke && i == 2) bus.start = 1'b0;
            tick();
            if (bus.busy) nbusy++;
            if (bus.done) begin ndone++; at = i; end
            else if (i < 4) chk({tag, "_hold"}, 32'(bus.product), 32'(prev_prod));
        end
        chk({tag, "_ndone"}, ndone, 1);
        chk({tag, "_lat"}, at, 4);
        chk({tag, "_busy"}, nbusy, 5);
        chk({tag, "_prod"}, 32'(bus.product), 32'(exp_p));
        prev_prod = exp_p;
    endtask

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        prev_prod = '0;
        #2;
        chk("rst_prod", 32'(bus.product), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            tick();
            chk("idle_out", {bus.product, 14'd0, bus.busy, bus.done}, 0);
        end
        op(8'h0C, 8'h0D, "basic", 1'b0);
        op(8'hFF, 8'hFF, "ffff", 1'b0);
        op(8'h00, 8'hA5, "zero", 1'b0);
        op(8'h80, 8'h02, "pow2", 1'b0);
        op(8'h12, 8'h34, "busy_start", 1'b1);
        // abort mid-operation with an asynchronous reset between edges
        bus.a = 8'h55; bus.b = 8'h55; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_prod", 32'(bus.product), 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (bus.done) ndone++; end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); if (bus.done) ndone++; end
        chk("abort_nodone", ndone, 0);
        chk("abort_prod2", 32'(bus.product), 0);
        prev_prod = '0;
        op(8'h03, 8'h07, "after_abort", 1'b0);
        // back-to-back with start held high and operands changing every cycle
        next_ok = 0; got = 0;
        for (int e = 0; e < 6100 && got < 1000; e++) begin
            da = 8'($urandom); db = 8'($urandom);
            bus.a = da; bus.b = db; bus.start = 1'b1;
            tick();
            if (e >= next_ok) begin
                q_edge.push_back(e);
                q_prod.push_back(16'(da) * 16'(db));
                next_ok = e + 6;
            end
            exp_done = q_edge.size() > 0 && q_edge[0] + 4 == e;
            chk("b2b_done", 32'(bus.done), 32'(exp_done));
            if (exp_done) begin
                chk("b2b_prod", 32'(bus.product), 32'(q_prod[0]));
                void'(q_edge.pop_front());
                void'(q_prod.pop_front());
                got++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_count", got, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
